pipe_skid: RTL and testbench
============================

PIPE_SKID -- requirements
Module: pipe_skid

Interface
REQ-001 Parameter WIDTH, default 32: width of the data word carried through the stage.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream presents a word on in_data.
REQ-005 in_data  input  WIDTH  upstream word.
REQ-006 in_ready  output  1  stage can accept a word this cycle; driven directly from a flop.
REQ-007 out_valid  output  1  out_data holds a valid word; driven directly from a flop.
REQ-008 out_data  output  WIDTH  downstream word; driven directly from a flop.
REQ-009 out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 flush  input  1  discard all held words (pipeline kill).

Function
REQ-011 Upstream transfer SHALL occur when in_valid && in_ready at a rising edge; downstream transfer when out_valid && out_ready.
REQ-012 Storage SHALL be two WIDTH-bit registers: main (drives out_data) and skid; no combinational path from out_ready to in_ready.
REQ-013 State SHALL be one of EMPTY (main invalid, skid invalid), ONE (main valid, skid invalid), or TWO (main valid, skid valid); skid valid with main invalid is illegal.
REQ-014 EMPTY: on accept, the word loads main -> ONE; otherwise stays EMPTY.
REQ-015 ONE, accept and consume: the new word loads main -> ONE.
REQ-016 ONE, accept only: the new word loads skid -> TWO.
REQ-017 ONE, consume only: -> EMPTY.
REQ-018 ONE, neither: hold.
REQ-019 TWO, consume: the skid word moves to main -> ONE.
REQ-020 TWO, no consume: hold.
REQ-021 No accept is possible in TWO.
REQ-022 in_ready SHALL equal 1 exactly when the next state is not TWO, registered; in_ready is 0 only in TWO.
REQ-023 Latency SHALL be 1 cycle: a word accepted at edge N in EMPTY, or in ONE with a simultaneous consume, appears on out_data with out_valid=1 after edge N.
REQ-024 Throughput SHALL be one word per cycle sustained while out_ready=1.
REQ-025 Ordering SHALL be strict FIFO; no word is duplicated or lost except by flush or reset.
REQ-026 Data registers SHALL load only on transfer; out_data is held stable while out_valid && !out_ready.
REQ-027 flush=1 at an edge SHALL force the next state to EMPTY with in_ready=1, discarding main, skid, and any word offered in that cycle, regardless of in_valid or out_ready.
REQ-028 A downstream handshake in a flush cycle still counts as a consume of the current main word.
REQ-029 rst SHALL take priority over flush.
REQ-030 in_data SHALL be ignored whenever in_valid=0; out_data content is don't-care whenever out_valid=0.

Reset
REQ-031 While rst=1 at an edge, the next state SHALL be out_valid=0, in_ready=1, out_data=0, skid contents=0, state=EMPTY.
REQ-032 Reset mid-operation SHALL discard all held words with no partial transfer; the first accept is possible on the first edge with rst=0.
REQ-033 Before the first reset, outputs are undefined; the bench SHALL apply rst for at least 1 cycle.

Verification
REQ-034 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_data=0 after release; nothing accepted.
REQ-035 Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> the same values on out_data on the next 3 consecutive cycles; in_ready stays 1.
REQ-036 Backpressure: out_ready=0, push 0xA0 then 0xB0 -> in_ready=0 after the second edge and 0xC0 is held off. Then out_ready=1 -> out_data sequence 0xA0,0xB0,0xC0 with no gaps.
REQ-037 Stall hold: in ONE with 0x55, out_ready=0 for 5 cycles -> out_data=0x55 and out_valid=1 throughout.
REQ-038 Flush in TWO: with 0x01/0x02 held, flush=1 and in_valid=1 with data 0x03 -> next cycle out_valid=0 and in_ready=1; 0x01, 0x02 and 0x03 are never output.
REQ-039 Random: random in_valid/out_ready/flush over 10k cycles against a reference queue model -> FIFO order preserved, occupancy never exceeds 2, and in_ready/out_valid/out_data match the model every cycle.

Source files
------------

// File: rtl/pipe_skid.sv
// Two-entry skid stage: main drives the output, skid catches the word that
// arrives while main is stalled. Every output comes straight from a flop.
module pipe_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, nstate;
  logic [WIDTH-1:0] skid;
  logic             accept, consume;
  logic             load_main, load_skid, main_from_skid;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    nstate         = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          nstate    = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          nstate    = TWO;
        end else if (consume) begin
          nstate    = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so the only possible event is a drain.
        if (consume) begin
          main_from_skid = 1'b1;
          nstate         = ONE;
        end
      end
      default: nstate = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid      <= '0;
    end else if (flush) begin
      // Data registers keep their stale content; out_valid=0 makes it moot.
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= nstate;
      out_valid <= (nstate != EMPTY);
      in_ready  <= (nstate != TWO);
      if (load_main)           out_data <= in_data;
      else if (main_from_skid) out_data <= skid;
      if (load_skid)           skid     <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid.sv
// Directed and random stimulus for pipe_skid, checked every cycle against a
// queue model of a two-deep FIFO, plus literal expectations on directed runs.
module tb_pipe_skid;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;
  logic [WIDTH-1:0] q[$];

  pipe_skid #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: occupancy decides ready/valid; pop on consume, push on accept.
  always @(posedge clk) begin
    bit acc, con;
    if (rst) q.delete();
    else begin
      acc = in_valid && (q.size() < 2);
      con = out_ready && (q.size() > 0);
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("model_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      if (q.size() > 0) chk("model_out_data", out_data, q[0]);
    end
  end

  task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                      input logic fl, input logic r);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic ov, input logic ir,
                            input logic [WIDTH-1:0] d, input bit chk_d);
    chk({name, "_ov"}, {31'd0, out_valid}, {31'd0, ov});
    chk({name, "_ir"}, {31'd0, in_ready}, {31'd0, ir});
    if (chk_d) chk({name, "_data"}, out_data, d);
  endtask

  initial begin
    @(negedge clk);
    // Reset with a word offered: nothing may be taken.
    step(1, 32'hDEAD, 0, 0, 1);
    chk_en = 1'b1;
    step(1, 32'hDEAD, 0, 0, 1);
    expect_out("reset", 0, 1, 32'h0, 1);
    step(0, 0, 0, 0, 0);
    expect_out("reset_idle", 0, 1, 32'h0, 1);

    // Streaming at full rate.
    step(1, 32'h11, 1, 0, 0); expect_out("stream1", 1, 1, 32'h11, 1);
    step(1, 32'h22, 1, 0, 0); expect_out("stream2", 1, 1, 32'h22, 1);
    step(1, 32'h33, 1, 0, 0); expect_out("stream3", 1, 1, 32'h33, 1);
    step(0, 0, 1, 0, 0);      expect_out("stream_end", 0, 1, 0, 0);

    // Backpressure fills skid, then drains without gaps.
    step(1, 32'hA0, 0, 0, 0); expect_out("bp_one", 1, 1, 32'hA0, 1);
    step(1, 32'hB0, 0, 0, 0); expect_out("bp_two", 1, 0, 32'hA0, 1);
    step(1, 32'hC0, 0, 0, 0); expect_out("bp_hold", 1, 0, 32'hA0, 1);
    step(1, 32'hC0, 1, 0, 0); expect_out("bp_drain1", 1, 1, 32'hB0, 1);
    step(1, 32'hC0, 1, 0, 0); expect_out("bp_drain2", 1, 1, 32'hC0, 1);
    step(0, 0, 1, 0, 0);      expect_out("bp_empty", 0, 1, 0, 0);

    // Stall hold in ONE.
    step(1, 32'h55, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 32'hFF, 0, 0, 0);
      expect_out("stall", 1, 1, 32'h55, 1);
    end
    step(0, 0, 1, 0, 0);      expect_out("stall_drain", 0, 1, 0, 0);

    // Flush in TWO discards everything including the offered word.
    step(1, 32'h01, 0, 0, 0);
    step(1, 32'h02, 0, 0, 0); expect_out("fl_two", 1, 0, 32'h01, 1);
    step(1, 32'h03, 0, 1, 0); expect_out("fl_two_kill", 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);      expect_out("fl_after", 0, 1, 0, 0);

    // Flush in ONE with a simultaneous handshake.
    step(1, 32'h07, 0, 0, 0);
    step(1, 32'h08, 1, 1, 0); expect_out("fl_one_kill", 0, 1, 0, 0);

    // Reset mid-operation, then accept on the first free edge.
    step(1, 32'h0A, 0, 0, 0);
    step(1, 32'h0B, 0, 0, 0);
    step(1, 32'h0C, 1, 0, 1); expect_out("midrst", 0, 1, 32'h0, 1);
    step(1, 32'h0D, 0, 0, 0); expect_out("midrst_acc", 1, 1, 32'h0D, 1);
    step(0, 0, 1, 0, 0);

    // Random traffic; the model compare covers every cycle.
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 511) == 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
